// File: rtl/relm_uart_tx_io.sv
// UART transmitter on the PE PUSH/POP interface: pushed bytes are queued in a
// small FIFO and sent 8N1 on txd; POP returns status and supports a drain request.
module relm_uart_tx_io #(
    parameter int WD   = 32,
    parameter int WAD  = 4,
    parameter int WDIV = 16,
    parameter int DIV  = 433
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [WD:0]   push_d,
    output logic          push_retry,
    input  logic [WD:0]   pop_d,
    output logic [WD:0]   pop_q,
    output logic          txd
);

    localparam int DEPTH = 1 << WAD;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          state, state_nx;
    logic [7:0]      mem [DEPTH];
    logic [WAD-1:0]  ra, wa;
    logic [WAD:0]    count;
    logic            full;
    logic [WDIV-1:0] div, div_l, per;
    logic [2:0]      bit_cnt;
    logic [7:0]      shift;
    logic            per_done, load, busy;
    logic            push_ok, push_byte, div_wr;
    logic [WD-1:0]   status;
    logic            unused_bits;

    // count never exceeds DEPTH, so its top bit alone marks full
    assign full       = count[WAD];
    assign push_retry = full;

    assign push_ok   = push_d[WD] & ~full;
    assign push_byte = push_ok & ~push_d[WD-1];
    assign div_wr    = push_ok & push_d[WD-1];
    assign per_done  = (per == div_l);

    always_comb begin
        state_nx = state;
        load     = 1'b0;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    load     = 1'b1;
                    state_nx = START;
                end
            end
            START: if (per_done) state_nx = DATA;
            DATA:  if (per_done && bit_cnt == 3'd7) state_nx = STOP;
            STOP: begin
                // chain straight into the next frame when more bytes are waiting
                if (per_done) begin
                    if (count != '0) begin
                        load     = 1'b1;
                        state_nx = START;
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            ra      <= '0;
            wa      <= '0;
            count   <= '0;
            div     <= WDIV'(DIV);
            div_l   <= WDIV'(DIV);
            per     <= '0;
            bit_cnt <= '0;
            shift   <= '0;
        end else begin
            state <= state_nx;
            if (div_wr) div <= push_d[WDIV-1:0];
            if (push_byte) wa <= wa + 1'b1;
            case ({push_byte, load})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (load) begin
                shift   <= mem[ra];
                div_l   <= div;
                ra      <= ra + 1'b1;
                per     <= '0;
                bit_cnt <= '0;
            end else if (state != IDLE) begin
                if (per_done) begin
                    per <= '0;
                    if (state == DATA) begin
                        shift   <= {1'b0, shift[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end else begin
                    per <= per + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_byte) mem[wa] <= push_d[7:0];
    end

    always_comb begin
        case (state)
            START:   txd = 1'b0;
            DATA:    txd = shift[0];
            default: txd = 1'b1;
        endcase
    end

    assign busy = (count != '0) | (state != IDLE);

    always_comb begin
        status          = '0;
        status[WD-1]    = full;
        status[WAD+1:1] = count;
        status[0]       = busy;
    end

    // a drain request is retried for as long as anything is queued or on the wire
    assign pop_q = {pop_d[WD] & pop_d[0] & busy, status};

    assign unused_bits = ^{push_d, pop_d};

endmodule

// File: tb/tb_relm_uart_tx_io.sv
// Bench for relm_uart_tx_io: a txd frame monitor checks every frame against a
// queue of expected bytes; scenario tasks check timing, flow control and status.
module tb_relm_uart_tx_io;

    localparam int WD   = 32;
    localparam int WAD  = 4;
    localparam int WDIV = 16;
    localparam int DIV  = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [WD:0]   push_d;
    logic          push_retry;
    logic [WD:0]   pop_d;
    logic [WD:0]   pop_q;
    logic          txd;

    int            n_cmp = 0;
    int            n_err = 0;
    int            cyc = 0;
    int            model_div = DIV;
    logic [7:0]    exp_q[$];
    int            start_q[$];

    relm_uart_tx_io #(.WD(WD), .WAD(WAD), .WDIV(WDIV), .DIV(DIV)) dut (
        .clk        (clk),
        .rst        (rst),
        .push_d     (push_d),
        .push_retry (push_retry),
        .pop_d      (pop_d),
        .pop_q      (pop_q),
        .txd        (txd)
    );

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    // frame monitor: pops the expected byte at the start bit, checks every sample
    int         mon_p;
    int         mon_start;
    int         mon_bitn;
    bit         mon_ok;
    bit         mon_abort;
    logic       mon_expb;
    logic [7:0] mon_eb;
    logic [7:0] mon_got;

    initial begin
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && txd === 1'b0) begin
                mon_p     = model_div + 1;
                mon_start = cyc;
                mon_ok    = 1'b1;
                mon_abort = 1'b0;
                mon_got   = '0;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_frame @%0d: got a start bit, required none (queue empty)", cyc);
                    mon_eb = 8'h00;
                end else begin
                    mon_eb = exp_q.pop_front();
                end
                for (int i = 0; i < 10 * mon_p; i++) begin
                    if (i > 0) @(negedge clk);
                    if (rst !== 1'b0) begin
                        mon_abort = 1'b1;
                        break;
                    end
                    mon_bitn = i / mon_p;
                    if (mon_bitn == 0)      mon_expb = 1'b0;
                    else if (mon_bitn == 9) mon_expb = 1'b1;
                    else                    mon_expb = mon_eb[mon_bitn-1];
                    if (txd !== mon_expb) mon_ok = 1'b0;
                    if (mon_bitn >= 1 && mon_bitn <= 8 && (i % mon_p) == mon_p / 2)
                        mon_got[mon_bitn-1] = txd;
                end
                if (!mon_abort) begin
                    n_cmp++;
                    start_q.push_back(mon_start);
                    if (!mon_ok) begin
                        n_err++;
                        $display("FAIL frame @%0d: got byte %02h (waveform wrong), required byte %02h with %0d-cycle bits",
                                 mon_start, mon_got, mon_eb, mon_p);
                    end
                end
            end
        end
    end

    // driver tasks
    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [31:0] w, output bit acc);
        acc = !push_retry;
        push_d = {1'b1, w};
        if (acc && !w[31]) exp_q.push_back(w[7:0]);
        @(posedge clk);
        #1;
        push_d = '0;
        if (acc && w[31]) model_div = int'(w[15:0]);
    endtask

    task automatic wait_until(input int c);
        @(negedge clk);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic wait_idle(input int budget);
        int i;
        i = 0;
        @(negedge clk);
        while (pop_q[0] !== 1'b0 && i < budget) begin
            @(negedge clk);
            i++;
        end
        n_cmp++;
        if (pop_q[0] !== 1'b0) begin
            n_err++;
            $display("FAIL idle_timeout: busy still %b after %0d cycles, required 0", pop_q[0], budget);
        end
    endtask

    task automatic check_gap(input string name, input int req);
        int a;
        int b;
        n_cmp++;
        if (start_q.size() < 2) begin
            n_err++;
            $display("FAIL %s: got %0d frames, required at least 2", name, start_q.size());
        end else begin
            a = start_q[start_q.size()-2];
            b = start_q[start_q.size()-1];
            if (b - a !== req) begin
                n_err++;
                $display("FAIL %s: got start gap %0d, required %0d", name, b - a, req);
            end
        end
    endtask

    // scenarios
    task automatic test_reset();
        rst    = 1'b1;
        push_d = '0;
        pop_d  = {1'b1, 32'h1};
        #1;
        n_cmp++;
        if ({txd, push_retry, pop_q} !== {1'b1, 1'b0, 33'h0}) begin
            n_err++;
            $display("FAIL reset_outputs: got txd=%b retry=%b pop_q=%h, required 1 0 0", txd, push_retry, pop_q);
        end
        repeat (3) @(posedge clk);
        #1;
        rst   = 1'b0;
        pop_d = '0;
        @(negedge clk);
        n_cmp++;
        if ({txd, push_retry, pop_q} !== {1'b1, 1'b0, 33'h0}) begin
            n_err++;
            $display("FAIL post_reset: got txd=%b retry=%b pop_q=%h, required 1 0 0", txd, push_retry, pop_q);
        end
    endtask

    task automatic test_single();
        bit acc;
        int k;
        sync();
        push_word(32'h55, acc);
        k = cyc;
        wait_until(k + 40);
        n_cmp++;
        if (pop_q[0] !== 1'b1) begin
            n_err++;
            $display("FAIL single_busy_last_stop: got busy=%b, required 1", pop_q[0]);
        end
        wait_until(k + 41);
        n_cmp++;
        if (pop_q[0] !== 1'b0 || txd !== 1'b1) begin
            n_err++;
            $display("FAIL single_idle: got busy=%b txd=%b, required 0 1", pop_q[0], txd);
        end
        n_cmp++;
        if (start_q.size() == 0 || start_q[start_q.size()-1] !== k + 1) begin
            n_err++;
            $display("FAIL single_latency: got start cycle %0d, required %0d",
                     (start_q.size() == 0) ? -1 : start_q[start_q.size()-1], k + 1);
        end
    endtask

    task automatic test_fill();
        bit acc;
        int k;
        int n_acc;
        int last_acc;
        n_acc = 0;
        last_acc = -1;
        k = 0;
        sync();
        for (int i = 0; i < 18; i++) begin
            push_word(32'($urandom_range(0, 255)), acc);
            if (i == 0) k = cyc;
            if (acc) begin
                n_acc++;
                last_acc = cyc;
            end
        end
        n_cmp++;
        if (n_acc !== 17 || last_acc !== k + 16) begin
            n_err++;
            $display("FAIL fill_accepts: got %0d accepted (last @%0d), required 17 (last @%0d)", n_acc, last_acc, k + 16);
        end
        @(negedge clk);
        n_cmp++;
        if (push_retry !== 1'b1 || pop_q[WD-1] !== 1'b1 || pop_q[WAD+1:1] !== 5'd16) begin
            n_err++;
            $display("FAIL fill_status: got retry=%b full=%b count=%0d, required 1 1 16",
                     push_retry, pop_q[WD-1], pop_q[WAD+1:1]);
        end
        sync();
        push_word(32'h8000_0000, acc);
        n_cmp++;
        if (acc !== 1'b0) begin
            n_err++;
            $display("FAIL fill_div_rejected: got accepted=%b, required 0", acc);
        end
        wait_until(k + 40);
        n_cmp++;
        if (push_retry !== 1'b1) begin
            n_err++;
            $display("FAIL fill_retry_held: got retry=%b, required 1", push_retry);
        end
        wait_until(k + 41);
        n_cmp++;
        if (push_retry !== 1'b0 || pop_q[WAD+1:1] !== 5'd15) begin
            n_err++;
            $display("FAIL fill_slot_freed: got retry=%b count=%0d, required 0 15", push_retry, pop_q[WAD+1:1]);
        end
        wait_idle(17 * 40 + 100);
    endtask

    task automatic test_div_change();
        bit acc;
        int k;
        sync();
        push_word(32'h3C, acc);
        k = cyc;
        push_word(32'hA5, acc);
        repeat (10) @(posedge clk);
        #1;
        push_word(32'h8000_0001, acc);
        wait_until(k + 60);
        n_cmp++;
        if (pop_q[0] !== 1'b1) begin
            n_err++;
            $display("FAIL div_busy_end: got busy=%b, required 1", pop_q[0]);
        end
        wait_until(k + 61);
        n_cmp++;
        if (pop_q[0] !== 1'b0) begin
            n_err++;
            $display("FAIL div_second_frame_len: got busy=%b, required 0", pop_q[0]);
        end
        check_gap("div_frame_gap", 40);
        sync();
        push_word(32'h8000_0000 | 32'(DIV), acc);
    endtask

    task automatic test_drain();
        bit acc;
        int k;
        sync();
        push_word(32'hC3, acc);
        k = cyc;
        push_word(32'h18, acc);
        pop_d = {1'b1, 32'h0};
        @(negedge clk);
        n_cmp++;
        if (pop_q[WD] !== 1'b0 || pop_q[0] !== 1'b1) begin
            n_err++;
            $display("FAIL status_read: got retry=%b busy=%b, required 0 1", pop_q[WD], pop_q[0]);
        end
        @(posedge clk);
        #1;
        pop_d = {1'b1, 32'h1};
        @(negedge clk);
        while (cyc <= k + 80) begin
            n_cmp++;
            if (pop_q[WD] !== 1'b1) begin
                n_err++;
                $display("FAIL drain_retry @%0d: got retry=%b, required 1", cyc, pop_q[WD]);
            end
            @(negedge clk);
        end
        n_cmp++;
        if (pop_q[WD] !== 1'b0 || pop_q[0] !== 1'b0) begin
            n_err++;
            $display("FAIL drain_done @%0d: got retry=%b busy=%b, required 0 0", cyc, pop_q[WD], pop_q[0]);
        end
        pop_d = '0;
    endtask

    task automatic test_back_to_back();
        bit acc;
        sync();
        push_word(32'h00, acc);
        push_word(32'hFF, acc);
        wait_idle(200);
        check_gap("b2b_gap", 40);
    endtask

    task automatic test_reset_mid_frame();
        bit acc;
        sync();
        push_word(32'h0F, acc);
        push_word(32'h12, acc);
        push_word(32'h34, acc);
        repeat (6) @(posedge clk);
        #3;
        rst   = 1'b1;
        pop_d = {1'b1, 32'h1};
        #1;
        n_cmp++;
        if ({txd, push_retry, pop_q} !== {1'b1, 1'b0, 33'h0}) begin
            n_err++;
            $display("FAIL mid_reset_async: got txd=%b retry=%b pop_q=%h, required 1 0 0", txd, push_retry, pop_q);
        end
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({txd, push_retry, pop_q} !== {1'b1, 1'b0, 33'h0}) begin
            n_err++;
            $display("FAIL mid_reset_held: got txd=%b retry=%b pop_q=%h, required 1 0 0", txd, push_retry, pop_q);
        end
        @(posedge clk);
        #1;
        exp_q.delete();
        model_div = DIV;
        rst   = 1'b0;
        pop_d = '0;
        repeat (5) @(negedge clk);
        n_cmp++;
        if (txd !== 1'b1 || pop_q !== 33'h0) begin
            n_err++;
            $display("FAIL after_mid_reset: got txd=%b pop_q=%h, required 1 0", txd, pop_q);
        end
        sync();
        push_word(32'h69, acc);
        wait_idle(100);
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_div_change();
        test_drain();
        test_back_to_back();
        test_reset_mid_frame();
        repeat (2) @(negedge clk);
        n_cmp++;
        if (exp_q.size() !== 0) begin
            n_err++;
            $display("FAIL leftover_bytes: got %0d untransmitted, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
